// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator with RUN/HALT/STEP control.
// Each channel emits a one-cycle tick every div+1 cycles and a square wave toggling per tick.
module clock_enable_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = 20_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic                 step_req,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_ch,
    input  logic [CNT_W-1:0]     cfg_div,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    divided_clk
);

    localparam logic [1:0]       MODE_RUN  = 2'b01;
    localparam logic [1:0]       MODE_STEP = 2'b10;
    localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [NUM_CH-1:0][CNT_W-1:0] r_div;
    logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_CH-1:0]            r_tick;
    logic [NUM_CH-1:0]            r_dclk;
    logic                         r_step_q;

    logic [NUM_CH-1:0][CNT_W-1:0] w_div_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NUM_CH-1:0]            w_tick_nxt;
    logic [NUM_CH-1:0]            w_dclk_nxt;
    logic                         w_run;
    logic                         w_step;

    assign w_run  = (mode == MODE_RUN);
    assign w_step = (mode == MODE_STEP) && step_req && !r_step_q;

    // Per-channel next state; a divisor write to a channel beats RUN counting and STEP.
    always_comb begin
        w_div_nxt  = r_div;
        w_cnt_nxt  = r_cnt;
        w_tick_nxt = '0;
        w_dclk_nxt = r_dclk;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cfg_we && (cfg_ch == 3'(c))) begin
                w_div_nxt[c] = cfg_div;
                w_cnt_nxt[c] = '0;
            end else if (w_run) begin
                if (r_cnt[c] == r_div[c]) begin
                    w_cnt_nxt[c]  = '0;
                    w_tick_nxt[c] = 1'b1;
                    w_dclk_nxt[c] = ~r_dclk[c];
                end else begin
                    w_cnt_nxt[c] = r_cnt[c] + CNT_ONE;
                end
            end else if (w_step) begin
                w_cnt_nxt[c]  = '0;
                w_tick_nxt[c] = 1'b1;
                w_dclk_nxt[c] = ~r_dclk[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_div[c] <= DIV_RST;
                r_cnt[c] <= '0;
            end
            r_tick   <= '0;
            r_dclk   <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tick   <= w_tick_nxt;
            r_dclk   <= w_dclk_nxt;
            r_step_q <= step_req;
        end
    end

    assign tick        = r_tick;
    assign divided_clk = r_dclk;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen: elapsed-cycle model compared every cycle,
// plus directed scenario checks with hand-computed tick counts.
module tb_clock_enable_gen;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEFAULT_DIV = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              step_req;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] divided_clk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_enable_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .step_req    (step_req),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .tick        (tick),
        .divided_clk (divided_clk)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel ticks whenever the running-edge count since its last clear is a
    // multiple of div+1; the square wave is the parity of ticks issued since reset.
    int                m_div     [NUM_CH];
    int                m_elapsed [NUM_CH];
    int                m_nticks  [NUM_CH];
    logic [NUM_CH-1:0] exp_tick;
    logic [NUM_CH-1:0] exp_dclk;
    bit                m_prev_step;
    bit                m_valid = 1'b0;

    always @(posedge clk) begin
        bit step_now;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c]     = DEFAULT_DIV;
                m_elapsed[c] = 0;
                m_nticks[c]  = 0;
            end
            exp_tick    = '0;
            m_prev_step = 1'b0;
            m_valid     = 1'b1;
        end else begin
            step_now = (mode == 2'b10) && step_req && !m_prev_step;
            for (int c = 0; c < NUM_CH; c++) begin
                exp_tick[c] = 1'b0;
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    m_div[c]     = int'(cfg_div);
                    m_elapsed[c] = 0;
                end else if (mode == 2'b01) begin
                    m_elapsed[c]++;
                    if ((m_elapsed[c] % (m_div[c] + 1)) == 0) begin
                        exp_tick[c] = 1'b1;
                        m_nticks[c]++;
                    end
                end else if (step_now) begin
                    exp_tick[c]  = 1'b1;
                    m_nticks[c]++;
                    m_elapsed[c] = 0;
                end
            end
            m_prev_step = step_req;
        end
        for (int c = 0; c < NUM_CH; c++) exp_dclk[c] = m_nticks[c][0];
    end

    // Per-cycle compare and observed tick tally.
    int n_tick [NUM_CH] = '{default: 0};
    int snap   [NUM_CH] = '{default: 0};

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_tick", int'(tick), int'(exp_tick));
            check("cyc_divided_clk", int'(divided_clk), int'(exp_dclk));
            for (int c = 0; c < NUM_CH; c++) if (tick[c]) n_tick[c]++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic take_snap();
        for (int c = 0; c < NUM_CH; c++) snap[c] = n_tick[c];
    endtask

    task automatic check_ticks(input string name, input int exp0, input int exp1);
        check({name, "_ch0_ticks"}, n_tick[0] - snap[0], exp0);
        check({name, "_ch1_ticks"}, n_tick[1] - snap[1], exp1);
    endtask

    initial begin
        reset    = 1'b1;
        mode     = 2'b00;
        step_req = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = 3'd0;
        cfg_div  = '0;
        cyc(2);
        check("reset_tick", int'(tick), 0);
        check("reset_divided_clk", int'(divided_clk), 0);

        // Default divisor 3: four ticks in 16 RUN cycles, square wave back to 0.
        reset = 1'b0;
        mode  = 2'b01;
        take_snap();
        cyc(3);
        check_ticks("run_first3", 0, 0);
        cyc(1);
        check_ticks("run_first_tick", 1, 1);
        cyc(12);
        check_ticks("run16", 4, 4);
        check("run16_divided_clk", int'(divided_clk), 0);

        // Halt at cnt=2, resume: tick exactly on the second resumed edge.
        cyc(2);
        mode = 2'b00;
        take_snap();
        cyc(10);
        check_ticks("halt", 0, 0);
        check("halt_divided_clk", int'(divided_clk), 0);
        mode = 2'b01;
        take_snap();
        cyc(1);
        check_ticks("resume1", 0, 0);
        cyc(1);
        check_ticks("resume2", 1, 1);

        // ch1 divisor 0: ticks every cycle; ch0 keeps every 4th cycle.
        cfg_we  = 1'b1;
        cfg_ch  = 3'd1;
        cfg_div = 8'd0;
        take_snap();
        cyc(1);
        check_ticks("wr_div0", 0, 0);
        cfg_we = 1'b0;
        take_snap();
        cyc(8);
        check_ticks("div0_run8", 2, 8);

        // Reset mid-count overrides a write and a step request on the same edge.
        reset    = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_div  = 8'd7;
        step_req = 1'b1;
        cyc(1);
        check("midrst_tick", int'(tick), 0);
        check("midrst_divided_clk", int'(divided_clk), 0);
        reset    = 1'b0;
        cfg_we   = 1'b0;
        step_req = 1'b0;
        take_snap();
        cyc(3);
        check_ticks("postrst3", 0, 0);
        cyc(1);
        check_ticks("postrst4", 1, 1);
        cyc(4);
        check_ticks("postrst8", 2, 2);
        check("postrst8_divided_clk", int'(divided_clk), 0);

        // Step edges ignored in HALT and in mode 11.
        mode = 2'b00;
        cyc(1);
        step_req = 1'b1;
        take_snap();
        cyc(2);
        step_req = 1'b0;
        mode     = 2'b11;
        cyc(1);
        step_req = 1'b1;
        cyc(3);
        check_ticks("halt_step", 0, 0);

        // STEP: held request gives one step; a second rising edge gives another.
        step_req = 1'b0;
        mode     = 2'b10;
        cyc(1);
        step_req = 1'b1;
        take_snap();
        cyc(5);
        check_ticks("step_held", 1, 1);
        step_req = 1'b0;
        cyc(2);
        step_req = 1'b1;
        cyc(3);
        check_ticks("step_two", 2, 2);
        check("step_divided_clk", int'(divided_clk), 0);

        // Write to ch0 on a step edge: ch0 loads div=1, ch1 steps; cfg_ch=5 ignored.
        step_req = 1'b0;
        cyc(1);
        step_req = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_div  = 8'd1;
        take_snap();
        cyc(1);
        check_ticks("wr_vs_step", 0, 1);
        check("wr_vs_step_divided_clk", int'(divided_clk), 2);
        step_req = 1'b0;
        mode     = 2'b01;
        cfg_ch   = 3'd5;
        cfg_div  = 8'd9;
        take_snap();
        cyc(1);
        cfg_we = 1'b0;
        cyc(5);
        check_ticks("bad_ch_run6", 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
